// File: rtl/dfill_buf_if.sv
// dfill_buf_if: request, memory-beat and dsram-write signals of the line-fill buffer
interface dfill_buf_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int WAYS = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic [WAYS-1:0]       req_way;
  logic                  req_st;
  logic [31:0]           req_st_be;
  logic [255:0]          req_st_wd;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [63:0]           mem_data;
  logic [ADDR_WIDTH-1:0] ds_aq;
  logic [31:0]           ds_be;
  logic [255:0]          ds_wd;
  logic [WAYS-1:0]       ds_write;
  logic                  done;
  logic                  busy;
  modport master (
    output req_valid, req_idx, req_way, req_st, req_st_be, req_st_wd, mem_valid, mem_data,
    input  req_ready, mem_ready, ds_aq, ds_be, ds_wd, ds_write, done, busy
  );
  modport slave (
    input  req_valid, req_idx, req_way, req_st, req_st_be, req_st_wd, mem_valid, mem_data,
    output req_ready, mem_ready, ds_aq, ds_be, ds_wd, ds_write, done, busy
  );
endinterface

// File: rtl/dfill_buf.sv
// dfill_buf: collects four 64-bit beats, merges pending store bytes, and issues one full-line dsram write
module dfill_buf #(
  parameter int ADDR_WIDTH = 13,
  parameter int WAYS = 4
) (
  input logic        clk,
  input logic        reset,
  dfill_buf_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d, ds_aq_q, ds_aq_d;
  logic [WAYS-1:0]       way_q, way_d, ds_write_q, ds_write_d;
  logic [31:0]           st_be_q, st_be_d, ds_be_q, ds_be_d;
  logic [255:0]          st_wd_q, st_wd_d, line_q, line_d, ds_wd_q, ds_wd_d, merged;
  logic                  done_q, done_d, req_acc, beat_acc;
  assign req_acc  = bus.req_valid && state_q == IDLE;
  assign beat_acc = bus.mem_valid && state_q == FILL;
  always_comb begin
    line_d = line_q;
    if (beat_acc) line_d[{cnt_q, 6'd0} +: 64] = bus.mem_data;
  end
  always_comb begin
    merged = line_d;
    for (int i = 0; i < 32; i++) merged[8*i +: 8] = st_be_q[i] ? st_wd_q[8*i +: 8] : line_d[8*i +: 8];
  end
  always_comb begin
    state_d    = state_q == WRITE ? IDLE : state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    way_d      = way_q;
    st_be_d    = st_be_q;
    st_wd_d    = st_wd_q;
    ds_aq_d    = ds_aq_q;
    ds_wd_d    = ds_wd_q;
    ds_be_d    = '0;
    ds_write_d = '0;
    done_d     = 1'b0;
    if (req_acc) begin
      state_d = FILL;
      cnt_d   = 2'd0;
      idx_d   = bus.req_idx;
      way_d   = bus.req_way;
      st_be_d = bus.req_st ? bus.req_st_be : 32'd0;
      st_wd_d = bus.req_st_wd;
    end
    if (beat_acc) begin
      cnt_d = cnt_q + 2'd1;
      // the write outputs are loaded on the last beat's edge so they are flop-driven during WRITE
      if (cnt_q == 2'd3) begin
        state_d    = WRITE;
        ds_aq_d    = idx_q;
        ds_wd_d    = merged;
        ds_be_d    = '1;
        ds_write_d = way_q;
        done_d     = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      way_q      <= '0;
      st_be_q    <= '0;
      st_wd_q    <= '0;
      line_q     <= '0;
      ds_aq_q    <= '0;
      ds_wd_q    <= '0;
      ds_be_q    <= '0;
      ds_write_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      way_q      <= way_d;
      st_be_q    <= st_be_d;
      st_wd_q    <= st_wd_d;
      line_q     <= line_d;
      ds_aq_q    <= ds_aq_d;
      ds_wd_q    <= ds_wd_d;
      ds_be_q    <= ds_be_d;
      ds_write_q <= ds_write_d;
      done_q     <= done_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.mem_ready = state_q == FILL;
  assign bus.busy      = state_q != IDLE;
  assign bus.ds_aq     = ds_aq_q;
  assign bus.ds_wd     = ds_wd_q;
  assign bus.ds_be     = ds_be_q;
  assign bus.ds_write  = ds_write_q;
  assign bus.done      = done_q;
endmodule

// File: doc/dfill_buf.md
# dfill_buf

Line-fill buffer directly upstream of the per-way `dsram` data arrays. It accepts a fill request (set index, victim way, optional pending store), collects four 64-bit beats from the memory side, and merges any store bytes over the fill data. It then issues a single-cycle, full-line write into the selected way's `dsram` using that array's `aq`/`be`/`wd`/`write` inputs.

## Interface
- `ADDR_WIDTH`, 13, set-index width; matches `dsram` `ADDR_WIDTH`
- `WAYS`, 4, number of ways; width of the one-hot way select
- `clk` in 1: the single clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `req_valid` in 1: fill request present
- `req_ready` out 1: high when in IDLE; the request is accepted on `req_valid & req_ready`
- `req_idx` in ADDR_WIDTH: set index to fill
- `req_way` in WAYS: one-hot victim way
- `req_st` in 1: a store merge accompanies the request
- `req_st_be` in 32: store byte enables, bit i = byte i
- `req_st_wd` in 256: store data, line-aligned
- `mem_valid` in 1: memory beat present
- `mem_ready` out 1: high when in FILL; a beat is accepted on `mem_valid & mem_ready`
- `mem_data` in 64: beat data; beat k carries line bits [64k+63:64k]
- `ds_aq` out ADDR_WIDTH: to `dsram.aq` of all ways
- `ds_be` out 32: to `dsram.be` of all ways
- `ds_wd` out 256: to `dsram.wd` of all ways
- `ds_write` out WAYS: bit w drives `dsram.write` of way w
- `done` out 1: one-cycle pulse, coincident with the line write
- `busy` out 1: high when not in IDLE

## Operation
- FSM with three states: IDLE, FILL, WRITE.
- IDLE -> FILL on request acceptance. On that edge the block latches `req_idx`, `req_way`, and the store enables/data. The store enables are latched as `req_st ? req_st_be : 0`. The 2-bit beat counter is cleared.
- FILL: each accepted beat is written to line slot `cnt`, then `cnt` increments.
- FILL -> WRITE on acceptance of the beat with `cnt == 3`. The counter wraps to 0.
- WRITE lasts exactly one cycle, then the FSM returns to IDLE unconditionally.
- Merge rule, per byte i: `ds_wd` byte i = latched `st_be[i]` ? latched store byte i : fill byte i.
- In WRITE: `ds_write = latched req_way`, `ds_be = 32'hFFFF_FFFF`, `ds_aq = latched idx`, `done = 1`.
- Outside WRITE: `ds_write = 0`, `ds_be = 0`, `done = 0`. `ds_aq` and `ds_wd` hold their last values.
- All `ds_*` outputs and `done` come from flops, not combinational paths.
- `mem_valid` outside FILL is ignored (`mem_ready = 0`), and no slot is modified.
- `req_valid` while busy is ignored and is not queued.
- `req_way == 0`: the full sequence runs and `done` pulses, but no array is written.
- Multi-hot `req_way`: every selected way is written. Upstream must not send this.
- A store with `req_st = 0` has no effect, whatever `req_st_be` carries.

## Timing
- Reset, asynchronous: state = IDLE, `cnt = 0`, and all registered outputs are 0. Immediately after reset `req_ready = 1`, `busy = 0`, `mem_ready = 0`.
- Reset asserted mid-FILL or in WRITE: the FSM returns to IDLE immediately, the partial line is discarded, and no `ds_write` is issued after reset.
- Request accepted at edge T: `mem_ready = 1` from cycle T+1.
- With back-to-back beats, the 4th beat is accepted at edge T+4. `ds_write`/`done` are high during T+4..T+5, and `dsram` captures at edge T+5.
- `req_ready` is high again from T+5. A new request can be accepted at edge T+6.
- Gaps in `mem_valid` stretch FILL with no limit. There is no timeout.
- A `dsram` read of the same `idx` issued in the WRITE cycle returns the old data. That hazard belongs to the cache controller, not to this block.

## Test plan
- Reset, then request `idx=0x005`, `way=4'b0010`, no store; beats `0x11..11`, `0x22..22`, `0x33..33`, `0x44..44` -> one cycle with `ds_write=4'b0010`, `ds_aq=0x005`, `ds_be=all ones`, `ds_wd={0x44..,0x33..,0x22..,0x11..}`, `done=1`.
- Same request with `req_st=1`, `req_st_be=32'h0000_0003`, store bytes 1:0 = `0xBEEF` -> `ds_wd[15:0]=0xBEEF`, all other bytes equal the fill data.
- Beats with 2-cycle bubbles between them -> exactly 4 beats captured, in order, and the write occurs one cycle after the last beat.
- `mem_valid` held high in IDLE, plus `req_valid` pulsed during FILL -> no slot is corrupted, the second request is not accepted, and exactly one `done` pulse follows.
- Assert `reset` after the 2nd beat, then run a full clean fill to `idx=0x1FFF`, `way=4'b1000` -> no write while in reset, and the clean fill writes correct data to `0x1FFF`.
- `req_way=0` -> `done` pulses and `ds_write` stays 0.
